// File: rtl/mem_fifo_loader.sv
// Loads NUM_ROWS 64-bit rows from the memory wrapper and streams each row,
// MSB byte first, into its own FIFO lane while honouring per-lane full flags.
module mem_fifo_loader #(
    parameter int NUM_ROWS      = 9,
    parameter int BYTES_PER_ROW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [31:0]         mem_address,
    output logic                mem_read,
    input  logic [63:0]         mem_readdata,
    input  logic                mem_readdatavalid,
    input  logic                mem_waitrequest,
    output logic [NUM_ROWS-1:0] fifo_wren,
    output logic [7:0]          fifo_wdata,
    input  logic [NUM_ROWS-1:0] fifo_full
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UNPACK = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(BYTES_PER_ROW - 1);

    logic [2:0]       state, state_n;
    logic [ROW_W-1:0] row, row_n;
    logic [2:0]       byte_cnt, byte_cnt_n;
    logic [63:0]      row_reg, row_reg_n;
    logic             lane_ready;

    // The row register shifts left on every write, so the byte being written
    // is always its top byte and fifo_wdata comes straight from a flop.
    assign lane_ready = (state == S_UNPACK) && !fifo_full[row];
    assign fifo_wren  = (lane_ready && !rst) ? (NUM_ROWS'(1) << row) : '0;
    assign fifo_wdata = row_reg[63:56];

    always_comb begin
        // NOTE: every next-state variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_n    = state;
        row_n      = row;
        byte_cnt_n = byte_cnt;
        row_reg_n  = row_reg;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_REQ;
                    row_n   = '0;
                end
            end
            S_REQ: begin
                if (!mem_waitrequest) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (mem_readdatavalid) begin
                    row_reg_n  = mem_readdata;
                    byte_cnt_n = '0;
                    state_n    = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (lane_ready) begin
                    row_reg_n = {row_reg[55:0], 8'h00};
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_n = '0;
                        if (row == LAST_ROW) begin
                            state_n = S_DONE;
                        end else begin
                            row_n   = row + 1'b1;
                            state_n = S_REQ;
                        end
                    end else begin
                        byte_cnt_n = byte_cnt + 3'd1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            row         <= '0;
            byte_cnt    <= '0;
            row_reg     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state       <= state_n;
            row         <= row_n;
            byte_cnt    <= byte_cnt_n;
            row_reg     <= row_reg_n;
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
            mem_read    <= (state_n == S_REQ);
            mem_address <= (state_n == S_REQ) ? 32'(row_n) : '0;
        end
    end

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Directed bench for mem_fifo_loader: a small memory responder plus a byte
// scoreboard filled when row data is returned and drained on FIFO writes.
module tb_mem_fifo_loader;

    localparam int NUM_ROWS      = 9;
    localparam int BYTES_PER_ROW = 8;

    logic                clk, rst, start, busy, done;
    logic [31:0]         mem_address;
    logic                mem_read, mem_readdatavalid, mem_waitrequest;
    logic [63:0]         mem_readdata;
    logic [NUM_ROWS-1:0] fifo_wren, fifo_full;
    logic [7:0]          fifo_wdata;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [63:0] mem [NUM_ROWS];
    logic [15:0] exp_q[$];
    int          exp_addr[$];
    int          lane_cnt [NUM_ROWS];
    int          n_req, n_wr, done_cnt, done_cyc, mem_lat;
    bit          resp_pending;
    int          resp_due, resp_addr;
    bit          bp_armed, wr_armed, spur_armed;
    int          bp_left, wr_left;

    mem_fifo_loader #(.NUM_ROWS(NUM_ROWS), .BYTES_PER_ROW(BYTES_PER_ROW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
        .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder and FIFO flags for the current cycle; a returned row
    // pushes its eight expected bytes (MSB first) into the scoreboard.
    task automatic drive_inputs();
        logic [63:0] d;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
        if (resp_pending && cyc == resp_due) begin
            d = mem[resp_addr];
            mem_readdatavalid = 1'b1;
            mem_readdata      = d;
            resp_pending      = 1'b0;
            for (int k = 0; k < BYTES_PER_ROW; k++)
                exp_q.push_back({8'(resp_addr), d[63-8*k -: 8]});
        end else if (spur_armed && lane_cnt[2] == 3 && !resp_pending) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = 64'hDEAD_BEEF_CAFE_F00D;
            spur_armed        = 1'b0;
        end
        if (bp_armed && lane_cnt[3] == 2) begin
            bp_left  = 5;
            bp_armed = 1'b0;
        end
        for (int i = 0; i < NUM_ROWS; i++) fifo_full[i] = (lane_cnt[i] >= BYTES_PER_ROW);
        if (bp_left > 0) fifo_full[3] = 1'b1;
        if (wr_armed && mem_read === 1'b1 && mem_address === 32'd1) begin
            wr_left  = 3;
            wr_armed = 1'b0;
        end
        mem_waitrequest = (wr_left > 0);
    endtask

    task automatic monitor();
        logic [15:0] e;
        if (mem_waitrequest) begin
            check("req_held_read", mem_read, 1);
            check("req_held_addr", mem_address, 1);
            wr_left--;
        end
        if (mem_read && !mem_waitrequest) begin
            n_req++;
            if (exp_addr.size() == 0) check("req_unexpected", mem_address, 64'hFFFF_FFFF);
            else check("req_addr", mem_address, exp_addr.pop_front());
            resp_pending = 1'b1;
            resp_due     = cyc + mem_lat;
            resp_addr    = int'(mem_address[3:0]) % NUM_ROWS;
        end
        if (bp_left > 0) bp_left--;
        if (fifo_wren != '0) begin
            n_wr++;
            check("wren_to_full", fifo_wren & fifo_full, 0);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", fifo_wren, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_lane", fifo_wren, NUM_ROWS'(1) << e[15:8]);
                check("wr_byte", fifo_wdata, e[7:0]);
            end
            for (int i = 0; i < NUM_ROWS; i++) if (fifo_wren[i]) lane_cnt[i]++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
        #1;
        monitor();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mem_read"}, mem_read, 0);
        check({tag, "_fifo_wren"}, fifo_wren, 0);
        check({tag, "_mem_address"}, mem_address, 0);
        check({tag, "_fifo_wdata"}, fifo_wdata, 0);
    endtask

    task automatic run_load(input int lat, input int exp_len, input string tag);
        int t0;
        mem_lat  = lat;
        n_req    = 0;
        done_cnt = 0;
        done_cyc = 0;
        for (int i = 0; i < NUM_ROWS; i++) lane_cnt[i] = 0;
        for (int r = 0; r < NUM_ROWS; r++) exp_addr.push_back(r);
        t0    = cyc;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_c1"}, busy, 1);
        check({tag, "_read_c1"}, mem_read, 1);
        check({tag, "_addr_c1"}, mem_address, 0);
        for (int i = 0; i < 400 && done_cnt == 0; i++) step();
        check({tag, "_done_seen"}, done_cnt, 1);
        check({tag, "_done_latency"}, done_cyc - t0, exp_len);
        check({tag, "_busy_at_done"}, busy, 1);
        step();
        check({tag, "_done_pulse_end"}, done, 0);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_requests"}, n_req, NUM_ROWS);
        for (int i = 0; i < NUM_ROWS; i++)
            check($sformatf("%s_lane%0d_writes", tag, i), lane_cnt[i], BYTES_PER_ROW);
        check({tag, "_bytes_left"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0; mem_readdata = '0; fifo_full = '0;
        resp_pending = 1'b0; bp_armed = 1'b0; wr_armed = 1'b0; spur_armed = 1'b0;
        bp_left = 0; wr_left = 0; mem_lat = 1; n_req = 0; n_wr = 0; done_cnt = 0; done_cyc = 0;
        for (int i = 0; i < NUM_ROWS; i++) lane_cnt[i] = 0;
        for (int r = 0; r < NUM_ROWS; r++) mem[r] = {8{8'(r + 1)}};

        // Reset, then idle with start low.
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (10) step();
        check("idle_requests", n_req, 0);
        check("idle_writes", n_wr, 0);
        check("idle_busy", busy, 0);

        // Basic load: 1 + 9*(1+1+8) cycles to done.
        run_load(1, 91, "basic");

        // Byte order with two-cycle read latency: 1 + 9*(1+2+8).
        mem[0] = 64'h0102_0304_0506_0708;
        run_load(2, 100, "order");

        // Lane 3 full for 5 cycles at byte 2 of row 3.
        bp_armed = 1'b1;
        run_load(1, 96, "bp");
        check("bp_applied", bp_armed, 0);

        // Waitrequest held 3 cycles on row 1, plus a stray valid during row 2 unpack.
        wr_armed   = 1'b1;
        spur_armed = 1'b1;
        run_load(1, 94, "waitreq");
        check("waitreq_applied", wr_armed, 0);
        check("spurious_applied", spur_armed, 0);

        // Reset in the middle of row 4, then a clean reload.
        mem_lat = 1;
        for (int i = 0; i < NUM_ROWS; i++) lane_cnt[i] = 0;
        for (int r = 0; r < NUM_ROWS; r++) exp_addr.push_back(r);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200 && lane_cnt[4] < 3; i++) step();
        check("rst_reached_row4", lane_cnt[4], 3);
        rst = 1'b1;
        step();
        check_all_zero("midload_rst");
        rst = 1'b0;
        exp_q.delete();
        exp_addr.delete();
        resp_pending = 1'b0;
        n_req = 0;
        n_wr  = 0;
        repeat (5) step();
        check("post_rst_requests", n_req, 0);
        check("post_rst_writes", n_wr, 0);
        run_load(1, 91, "reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
